// File: rtl/tpm_reg_arbiter.sv
// Bridges the byte-wise SPI data-provider handshake and a local core requester onto one 32-bit register bus.
// Optional bus timeout is built when TPM_BUS_TIMEOUT_EN is defined.
module tpm_reg_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic [15:0] spi_addr_i,
  input  logic [7:0]  spi_wdata_i,
  input  logic        spi_wr_i,
  output logic        spi_wr_done_o,
  input  logic        spi_req_i,
  output logic [7:0]  spi_rdata_o,
  output logic        spi_rd_o,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [15:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_be_i,
  output logic        core_ack_o,
  output logic [31:0] core_rdata_o,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [15:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_be_o,
  input  logic        reg_ack_i,
  input  logic [31:0] reg_rdata_i,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GNT_SPI, S_GNT_CORE, S_SPI_HS, S_CORE_ACK
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic cs_s, wr_s, req_s;
  logic wr_prev_q, req_prev_q;
  logic wr_rise, req_rise;

  logic        spi_pend_q, spi_pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic        op_wr_q, op_wr_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  lane_sum;
  logic        lane_ok;
  logic        spi_need_bus;
  logic        spi_strobe;
  logic        hs_q, hs_d;
  logic        last_spi_q, last_spi_d;
  logic [31:0] cache_q, cache_d;
  logic        cache_vld_q, cache_vld_d;
  logic [7:0]  spi_rdata_q, spi_rdata_d;
  logic        core_ack_q, core_ack_d;
  logic [31:0] core_rdata_q, core_rdata_d;
  logic        reg_req_q, reg_req_d;
  logic        reg_we_q, reg_we_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic [3:0]  reg_be_q, reg_be_d;
  logic        tmo_hit;
  logic        bus_done;
  logic [31:0] bus_rdata;

  logic unused_ok;
  assign unused_ok = ^core_addr_i[1:0];

  always_comb begin
    cs_sync_d[0]  = cs_i;
    wr_sync_d[0]  = spi_wr_i;
    req_sync_d[0] = spi_req_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      cs_sync_d[i]  = cs_sync_q[i-1];
      wr_sync_d[i]  = wr_sync_q[i-1];
      req_sync_d[i] = req_sync_q[i-1];
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign wr_s     = wr_sync_q[SYNC_STAGES-1];
  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign wr_rise  = wr_s & ~wr_prev_q;
  assign req_rise = req_s & ~req_prev_q;

  // Lane wraps in 3 bits; anything at or above 4 has no byte in this word.
  assign lane_sum     = {1'b0, spi_addr_i[1:0]} + idx_q;
  assign lane_ok      = ~lane_sum[2];
  assign spi_need_bus = pend_wr_q ? lane_ok : (idx_q == 3'd0);
  assign spi_strobe   = op_wr_q ? wr_s : req_s;

`ifdef TPM_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          in_gnt;

  always_comb begin
    in_gnt    = (state_q == S_GNT_SPI) || (state_q == S_GNT_CORE);
    tmo_hit   = in_gnt && !reg_ack_i && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d = (in_gnt && !reg_ack_i && !tmo_hit) ? tmo_cnt_q + TW'(1) : '0;
    bus_err_d = bus_err_q | tmo_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign bus_err_o  = 1'b0;
`endif

  assign bus_done  = reg_ack_i | tmo_hit;
  assign bus_rdata = reg_ack_i ? reg_rdata_i : 32'hFFFF_FFFF;

  always_comb begin
    state_d      = state_q;
    spi_pend_d   = spi_pend_q;
    pend_wr_d    = pend_wr_q;
    op_wr_d      = op_wr_q;
    lane_d       = lane_q;
    idx_d        = idx_q;
    last_spi_d   = last_spi_q;
    cache_d      = cache_q;
    cache_vld_d  = cache_vld_q;
    spi_rdata_d  = spi_rdata_q;
    core_ack_d   = 1'b0;
    core_rdata_d = core_rdata_q;
    reg_req_d    = reg_req_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_be_d     = reg_be_q;
    hs_d         = (state_q == S_SPI_HS) && spi_strobe;

    // Edges are latched here so a strobe arriving while the core owns the bus waits its turn.
    if (wr_rise || req_rise) begin
      spi_pend_d = 1'b1;
      pend_wr_d  = wr_rise;
    end

    case (state_q)
      S_IDLE: begin
        if (spi_pend_q && (!core_req_i || !last_spi_q)) begin
          spi_pend_d = 1'b0;
          last_spi_d = 1'b1;
          op_wr_d    = pend_wr_q;
          lane_d     = lane_sum[1:0];
          if (spi_need_bus) begin
            state_d     = S_GNT_SPI;
            reg_req_d   = 1'b1;
            reg_we_d    = pend_wr_q;
            reg_addr_d  = {spi_addr_i[15:2], 2'b00};
            reg_wdata_d = {4{spi_wdata_i}};
            reg_be_d    = pend_wr_q ? 4'(4'b0001 << lane_sum[1:0]) : 4'hF;
          end else begin
            state_d = S_SPI_HS;
            if (!pend_wr_q) begin
              spi_rdata_d = (lane_ok && cache_vld_q) ?
                            cache_q[{lane_sum[1:0], 3'b000} +: 8] : 8'hFF;
            end
          end
        end else if (core_req_i) begin
          state_d     = S_GNT_CORE;
          last_spi_d  = 1'b0;
          reg_req_d   = 1'b1;
          reg_we_d    = core_we_i;
          reg_addr_d  = {core_addr_i[15:2], 2'b00};
          reg_wdata_d = core_wdata_i;
          reg_be_d    = core_be_i;
        end
      end
      S_GNT_SPI: begin
        if (bus_done) begin
          reg_req_d = 1'b0;
          state_d   = S_SPI_HS;
          if (!op_wr_q) begin
            spi_rdata_d = bus_rdata[{lane_q, 3'b000} +: 8];
            cache_d     = bus_rdata;
            cache_vld_d = 1'b1;
          end
        end
      end
      S_GNT_CORE: begin
        if (bus_done) begin
          reg_req_d    = 1'b0;
          state_d      = S_CORE_ACK;
          core_ack_d   = 1'b1;
          core_rdata_d = bus_rdata;
        end
      end
      S_SPI_HS: begin
        if (!spi_strobe) begin
          state_d = S_IDLE;
          idx_d   = (idx_q == 3'd7) ? 3'd7 : idx_q + 3'd1;
        end
      end
      S_CORE_ACK: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Deselect clears the byte position only once any SPI access in flight has finished.
    if (cs_s && !spi_pend_q && (state_q != S_GNT_SPI) && (state_q != S_SPI_HS)) begin
      idx_d       = 3'd0;
      cache_vld_d = 1'b0;
    end
  end

  // Synchronisers reset high so a strobe already high at reset release never looks like a new edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync_q    <= '1;
      wr_sync_q    <= '1;
      req_sync_q   <= '1;
      wr_prev_q    <= 1'b1;
      req_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      spi_pend_q   <= 1'b0;
      pend_wr_q    <= 1'b0;
      op_wr_q      <= 1'b0;
      lane_q       <= 2'd0;
      idx_q        <= 3'd0;
      hs_q         <= 1'b0;
      last_spi_q   <= 1'b0;
      cache_q      <= 32'h0;
      cache_vld_q  <= 1'b0;
      spi_rdata_q  <= 8'hFF;
      core_ack_q   <= 1'b0;
      core_rdata_q <= 32'h0;
      reg_req_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= 16'h0;
      reg_wdata_q  <= 32'h0;
      reg_be_q     <= 4'h0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      wr_sync_q    <= wr_sync_d;
      req_sync_q   <= req_sync_d;
      wr_prev_q    <= wr_s;
      req_prev_q   <= req_s;
      state_q      <= state_d;
      spi_pend_q   <= spi_pend_d;
      pend_wr_q    <= pend_wr_d;
      op_wr_q      <= op_wr_d;
      lane_q       <= lane_d;
      idx_q        <= idx_d;
      hs_q         <= hs_d;
      last_spi_q   <= last_spi_d;
      cache_q      <= cache_d;
      cache_vld_q  <= cache_vld_d;
      spi_rdata_q  <= spi_rdata_d;
      core_ack_q   <= core_ack_d;
      core_rdata_q <= core_rdata_d;
      reg_req_q    <= reg_req_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_be_q     <= reg_be_d;
    end
  end

  assign spi_wr_done_o = hs_q & op_wr_q;
  assign spi_rd_o      = hs_q & ~op_wr_q;
  assign spi_rdata_o   = spi_rdata_q;
  assign core_ack_o    = core_ack_q;
  assign core_rdata_o  = core_rdata_q;
  assign reg_req_o     = reg_req_q;
  assign reg_we_o      = reg_we_q;
  assign reg_addr_o    = reg_addr_q;
  assign reg_wdata_o   = reg_wdata_q;
  assign reg_be_o      = reg_be_q;

endmodule

// File: tb/tb_tpm_reg_arbiter.sv
// Directed bench for tpm_reg_arbiter: SPI writes/reads, unaligned lanes, arbitration, reset behaviour.
module tb_tpm_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_i;
  logic [15:0] spi_addr_i;
  logic [7:0]  spi_wdata_i;
  logic        spi_wr_i;
  logic        spi_wr_done_o;
  logic        spi_req_i;
  logic [7:0]  spi_rdata_o;
  logic        spi_rd_o;
  logic        core_req_i;
  logic        core_we_i;
  logic [15:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [3:0]  core_be_i;
  logic        core_ack_o;
  logic [31:0] core_rdata_o;
  logic        reg_req_o;
  logic        reg_we_o;
  logic [15:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_be_o;
  logic        reg_ack_i;
  logic [31:0] reg_rdata_i;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tpm_reg_arbiter dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs_i),
    .spi_addr_i(spi_addr_i), .spi_wdata_i(spi_wdata_i), .spi_wr_i(spi_wr_i),
    .spi_wr_done_o(spi_wr_done_o), .spi_req_i(spi_req_i), .spi_rdata_o(spi_rdata_o),
    .spi_rd_o(spi_rd_o), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_be_i(core_be_i),
    .core_ack_o(core_ack_o), .core_rdata_o(core_rdata_o), .reg_req_o(reg_req_o),
    .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_be_o(reg_be_o), .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i),
    .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus(input string tag);
    int n = 0;
    while (!reg_req_o && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, reg_req_o}, 32'd1);
  endtask

  task automatic bus_ack(input string tag, input logic [31:0] d);
    reg_ack_i   = 1'b1;
    reg_rdata_i = d;
    tick();
    reg_ack_i   = 1'b0;
    reg_rdata_i = 32'h0;
    chk({tag, "_req_drop"}, {31'd0, reg_req_o}, 32'd0);
  endtask

  task automatic spi_wr_byte(input string tag, input logic [7:0] d, input logic exp_bus,
                             input logic [15:0] exp_addr, input logic [3:0] exp_be);
    int   n;
    logic seen = 1'b0;
    spi_wdata_i = d;
    spi_wr_i    = 1'b1;
    if (exp_bus) begin
      wait_bus(tag);
      chk({tag, "_we"},    {31'd0, reg_we_o}, 32'd1);
      chk({tag, "_addr"},  {16'd0, reg_addr_o}, {16'd0, exp_addr});
      chk({tag, "_be"},    {28'd0, reg_be_o}, {28'd0, exp_be});
      chk({tag, "_wdata"}, reg_wdata_o, {4{d}});
      bus_ack(tag, 32'h0);
    end
    n = 0;
    while (!spi_wr_done_o && n < 60) begin
      if (reg_req_o) seen = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_done_hi"}, {31'd0, spi_wr_done_o}, 32'd1);
    spi_wr_i = 1'b0;
    tick();
    chk({tag, "_done_hold"}, {31'd0, spi_wr_done_o}, 32'd1);
    n = 0;
    while (spi_wr_done_o && n < 60) begin
      if (reg_req_o) seen = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_done_lo"}, {31'd0, spi_wr_done_o}, 32'd0);
    if (!exp_bus) chk({tag, "_nobus"}, {31'd0, seen}, 32'd0);
  endtask

  task automatic spi_rd_byte(input string tag, input logic exp_bus, input logic [15:0] exp_addr,
                             input logic [31:0] bus_data, input logic [7:0] exp_byte);
    int         n;
    logic       seen = 1'b0;
    logic [7:0] prev;
    spi_req_i = 1'b1;
    if (exp_bus) begin
      wait_bus(tag);
      chk({tag, "_we"},   {31'd0, reg_we_o}, 32'd0);
      chk({tag, "_addr"}, {16'd0, reg_addr_o}, {16'd0, exp_addr});
      chk({tag, "_be"},   {28'd0, reg_be_o}, 32'hF);
      bus_ack(tag, bus_data);
    end
    n    = 0;
    prev = spi_rdata_o;
    while (!spi_rd_o && n < 60) begin
      if (reg_req_o) seen = 1'b1;
      prev = spi_rdata_o;
      tick();
      n++;
    end
    chk({tag, "_rd_hi"}, {31'd0, spi_rd_o}, 32'd1);
    chk({tag, "_data"}, {24'd0, spi_rdata_o}, {24'd0, exp_byte});
    chk({tag, "_data_early"}, {24'd0, prev}, {24'd0, exp_byte});
    spi_req_i = 1'b0;
    n = 0;
    while (spi_rd_o && n < 60) begin
      if (reg_req_o) seen = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_rd_lo"}, {31'd0, spi_rd_o}, 32'd0);
    if (!exp_bus) chk({tag, "_nobus"}, {31'd0, seen}, 32'd0);
  endtask

  task automatic cs_cycle();
    cs_i = 1'b1;
    repeat (5) tick();
    cs_i = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int   n;
    logic seen;
    rst = 1'b1; cs_i = 1'b1; spi_addr_i = 16'h0; spi_wdata_i = 8'h0;
    spi_wr_i = 1'b0; spi_req_i = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0;
    core_addr_i = 16'h0; core_wdata_i = 32'h0; core_be_i = 4'h0;
    reg_ack_i = 1'b0; reg_rdata_i = 32'h0;
    repeat (3) tick();
    chk("rst_reg_req", {31'd0, reg_req_o}, 32'd0);
    chk("rst_rdata",   {24'd0, spi_rdata_o}, 32'hFF);
    chk("rst_done",    {31'd0, spi_wr_done_o}, 32'd0);
    chk("rst_rd",      {31'd0, spi_rd_o}, 32'd0);
    chk("rst_core_ack", {31'd0, core_ack_o}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Aligned 4-byte write
    cs_i = 1'b0; spi_addr_i = 16'h4C4C;
    repeat (4) tick();
    spi_wr_byte("w0", 8'h3C, 1'b1, 16'h4C4C, 4'h1);
    spi_wr_byte("w1", 8'h35, 1'b1, 16'h4C4C, 4'h2);
    spi_wr_byte("w2", 8'h3C, 1'b1, 16'h4C4C, 4'h4);
    spi_wr_byte("w3", 8'h11, 1'b1, 16'h4C4C, 4'h8);

    // Aligned 4-byte read: one bus read then cache hits
    spi_addr_i = 16'hF0F0;
    cs_cycle();
    spi_rd_byte("r0", 1'b1, 16'hF0F0, 32'hFA005735, 8'h35);
    spi_rd_byte("r1", 1'b0, 16'h0, 32'h0, 8'h57);
    spi_rd_byte("r2", 1'b0, 16'h0, 32'h0, 8'h00);
    spi_rd_byte("r3", 1'b0, 16'h0, 32'h0, 8'hFA);

    // Unaligned read at 0x0012
    spi_addr_i = 16'h0012;
    cs_cycle();
    spi_rd_byte("ur0", 1'b1, 16'h0010, 32'hA1B2C3D4, 8'hB2);
    spi_rd_byte("ur1", 1'b0, 16'h0, 32'h0, 8'hA1);
    spi_rd_byte("ur2", 1'b0, 16'h0, 32'h0, 8'hFF);
    spi_rd_byte("ur3", 1'b0, 16'h0, 32'h0, 8'hFF);

    // Unaligned write at 0x4C43
    spi_addr_i = 16'h4C43;
    cs_cycle();
    spi_wr_byte("uw0", 8'h5A, 1'b1, 16'h4C40, 4'h8);
    spi_wr_byte("uw1", 8'h6B, 1'b0, 16'h0, 4'h0);
    spi_wr_byte("uw2", 8'h7C, 1'b0, 16'h0, 4'h0);
    spi_wr_byte("uw3", 8'h8D, 1'b0, 16'h0, 4'h0);

    // Arbitration from reset: SPI edge and core request reach IDLE together
    cs_i = 1'b1;
    rst  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cs_i = 1'b0; spi_addr_i = 16'h0030;
    repeat (4) tick();
    spi_wdata_i = 8'h77;
    spi_wr_i    = 1'b1;
    repeat (3) tick();
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 16'h0027;
    core_wdata_i = 32'h12345678; core_be_i = 4'hF;
    wait_bus("arb_spi");
    chk("arb_spi_addr", {16'd0, reg_addr_o}, 32'h0030);
    chk("arb_spi_be",   {28'd0, reg_be_o}, 32'h1);
    chk("arb_spi_wdata", reg_wdata_o, 32'h77777777);
    bus_ack("arb_spi", 32'h0);
    n = 0;
    while (!spi_wr_done_o && n < 60) begin tick(); n++; end
    chk("arb_spi_done", {31'd0, spi_wr_done_o}, 32'd1);
    chk("arb_core_wait", {31'd0, core_ack_o}, 32'd0);
    spi_wr_i = 1'b0;
    wait_bus("arb_core");
    chk("arb_core_we",    {31'd0, reg_we_o}, 32'd1);
    chk("arb_core_addr",  {16'd0, reg_addr_o}, 32'h0024);
    chk("arb_core_wdata", reg_wdata_o, 32'h12345678);
    chk("arb_core_be",    {28'd0, reg_be_o}, 32'hF);
    bus_ack("arb_core", 32'h0);
    chk("arb_core_ack", {31'd0, core_ack_o}, 32'd1);
    core_req_i = 1'b0;
    tick();
    chk("arb_core_ack_pulse", {31'd0, core_ack_o}, 32'd0);

    // Core read
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 16'h0008; core_be_i = 4'h3;
    wait_bus("core_rd");
    chk("core_rd_we",   {31'd0, reg_we_o}, 32'd0);
    chk("core_rd_addr", {16'd0, reg_addr_o}, 32'h0008);
    chk("core_rd_be",   {28'd0, reg_be_o}, 32'h3);
    bus_ack("core_rd", 32'hCAFEF00D);
    chk("core_rd_ack",  {31'd0, core_ack_o}, 32'd1);
    chk("core_rd_data", core_rdata_o, 32'hCAFEF00D);
    core_req_i = 1'b0;
    repeat (3) tick();

    // Reset mid-access with spi_req_i held high
    cs_cycle();
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 16'h0040;
    spi_addr_i = 16'h0104;
    spi_req_i  = 1'b1;
    wait_bus("rst_mid");
    rst = 1'b1;
    #1;
    chk("rst_mid_req_drop", {31'd0, reg_req_o}, 32'd0);
    core_req_i = 1'b0;
    repeat (2) tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (reg_req_o || spi_rd_o) seen = 1'b1;
    end
    chk("rst_held_req_ignored", {31'd0, seen}, 32'd0);
    spi_req_i = 1'b0;
    repeat (4) tick();
    spi_rd_byte("rr0", 1'b1, 16'h0104, 32'h11223344, 8'h44);

`ifdef TPM_BUS_TIMEOUT_EN
    cs_cycle();
    spi_addr_i = 16'h0200;
    spi_req_i  = 1'b1;
    wait_bus("tmo");
    n = 0;
    while (reg_req_o && n < 400) begin tick(); n++; end
    chk("tmo_cycles", n, 32'd255);
    n = 0;
    while (!spi_rd_o && n < 60) begin tick(); n++; end
    chk("tmo_rd_hi",   {31'd0, spi_rd_o}, 32'd1);
    chk("tmo_rdata",   {24'd0, spi_rdata_o}, 32'hFF);
    chk("tmo_bus_err", {31'd0, bus_err_o}, 32'd1);
    spi_req_i = 1'b0;
    repeat (6) tick();
    chk("tmo_bus_err_sticky", {31'd0, bus_err_o}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpm_reg_arbiter.md
Name: tpm_reg_arbiter

Overview:
Sits between the spi_periph data-provider interface and the TPM register bank. Converts byte-wise SPI write/read handshakes into 32-bit register-bus accesses. Shares that single register bus with a local core requester, using round-robin arbitration and at most one outstanding transaction. Handles byte-lane steering, read caching, and out-of-range lanes on unaligned accesses.

Parameters:
SYNC_STAGES, 2, flip-flop stages on cs_i, spi_wr_i and spi_req_i (these come from the SPI clock domain)
TIMEOUT_CYCLES, 255, maximum cycles to wait for reg_ack_i; used only with TPM_BUS_TIMEOUT_EN

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
cs_i  in  1  raw SPI chip select, active low
spi_addr_i  in  16  TPM address from spi_periph addr_o; stable while a strobe is high
spi_wdata_i  in  8  write byte from spi_periph data_o
spi_wr_i  in  1  write strobe from spi_periph data_wr
spi_wr_done_o  out  1  to spi_periph wr_done
spi_req_i  in  1  read request from spi_periph data_req
spi_rdata_o  out  8  to spi_periph data_i
spi_rd_o  out  1  to spi_periph data_rd
core_req_i  in  1  local request; held until core_ack_o
core_we_i  in  1  1 = write
core_addr_i  in  16  word address; bits [1:0] ignored
core_wdata_i  in  32  local write data
core_be_i  in  4  local byte enables
core_ack_o  out  1  one-cycle completion pulse
core_rdata_o  out  32  valid while core_ack_o is high
reg_req_o  out  1  bus request; held until reg_ack_i
reg_we_o  out  1  bus write enable
reg_addr_o  out  16  word-aligned bus address
reg_wdata_o  out  32  bus write data
reg_be_o  out  4  bus byte enables
reg_ack_i  in  1  one-cycle bus ack; reg_rdata_i valid with it
reg_rdata_i  in  32  bus read data
bus_err_o  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0, spi_rdata_o = 8'hFF, byte index = 0, read cache invalid, last-grant = core.
- Synchronisation: cs_i, spi_wr_i and spi_req_i each pass through SYNC_STAGES flip-flops. Edge detection runs on the synced levels.
- Edge-detect previous-value registers reset to 1. A strobe that is already high when reset is released is ignored until it has been seen low.
- Byte index:
  - 3-bit counter, cleared while synced cs is high.
  - Incremented on each completed SPI handshake; saturates at 7.
  - lane = spi_addr_i[1:0] + index, computed as a 3-bit sum. lane > 3 is out of range.
- SPI write (rising edge of synced spi_wr_i), lane in range:
  - Bus write to {spi_addr_i[15:2], 2'b00}.
  - reg_wdata_o = byte replicated to all four lanes; reg_be_o = one-hot at lane.
- SPI write, lane out of range: no bus access; handshake still completes.
- SPI read (rising edge of synced spi_req_i):
  - index == 0: full-word bus read (reg_be_o = 4'hF); result loaded into the cache.
  - index > 0 and lane in range: byte returned from the cache with no bus access.
  - Lane out of range: return 8'hFF.
  - spi_rdata_o is updated one cycle before spi_rd_o rises.
- SPI handshake is 4-phase:
  - Raise spi_wr_done_o / spi_rd_o one cycle after the access completes (reg_ack_i, or immediately when no bus access is needed).
  - Hold it until the synced strobe is seen low, then drop it the next cycle.
- Core path: bus access with core_be_i and core_wdata_i. core_ack_o pulses the cycle after reg_ack_i; core_rdata_o is latched from reg_rdata_i.
- FSM states: IDLE, GNT_SPI, GNT_CORE, SPI_HS (wait for strobe low), CORE_ACK.
  - IDLE -> GNT_x on a pending request.
  - GNT_x -> SPI_HS / CORE_ACK on reg_ack_i.
  - SPI_HS -> IDLE when the synced strobe is low.
  - CORE_ACK -> IDLE after one cycle.
- Arbitration:
  - SPI and core pending in the same cycle: grant whichever did not win last time; from reset, SPI wins.
  - A pending SPI edge is latched and never lost while the core holds the bus.
- Bus signals: reg_req_o and the bus address/data/enables are asserted on entry to GNT_x and held stable until reg_ack_i. reg_ack_i in IDLE is ignored.
- cs_i rising mid-operation: the active bus access and handshake still complete; the index is cleared afterwards.
- Reset mid-operation: all state returns to IDLE and reg_req_o drops immediately.

Optional Feature:
TPM_BUS_TIMEOUT_EN
- Defined:
  - A counter runs in GNT_SPI/GNT_CORE.
  - After TIMEOUT_CYCLES cycles without reg_ack_i: drop reg_req_o, complete the access with read data 32'hFFFFFFFF (writes are discarded), and set bus_err_o.
  - bus_err_o is cleared only by reset.
- Undefined: no counter, the FSM waits indefinitely, and bus_err_o is tied to 0.

Test Plan:
- SPI 4-byte write to 0x4C4C of 3C,35,3C,11 -> four bus writes to 0x4C4C with be 1,2,4,8. Each spi_wr_done_o deasserts after spi_wr_i falls.
- SPI 4-byte read at 0xF0F0 with reg_rdata_i = 32'hFA005735 -> exactly one bus read; bytes returned 35,57,00,FA.
- Unaligned 4-byte read at 0x0012 -> one bus read of 0x0010; bytes returned are lanes 2, 3, then FF, FF.
- Unaligned 4-byte write at 0x4C43 -> one bus write with be 8; the remaining three handshakes complete with no bus activity.
- Core request and SPI edge in the same cycle after reset -> SPI granted first, then core. Core write 32'h12345678 with be F appears intact on the bus.
- Reset asserted while spi_req_i is high -> no bus access until spi_req_i has been low and then risen again. Separately, with TPM_BUS_TIMEOUT_EN defined and reg_ack_i held 0 -> bus_err_o = 1 after 255 cycles and spi_rdata_o = FF.
